prio_encoder_rr_pipe: RTL and testbench

//  Parametrised N-input priority encoder with registered output and valid/ready handshake.

---
 rtl/prio_encoder_rr_pipe.sv | 120 ++++++++++++
 tb/tb_prio_encoder_rr_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_rr_pipe.sv
// N-input priority encoder (fixed-LSB, fixed-MSB or round-robin) with a single registered
// output stage, valid/ready handshake, binary code and re-decoded one-hot grant.
module prio_encoder_rr_pipe #(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = $clog2(N),
    parameter int unsigned MODE = 0
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    output logic         grant_valid,
    input  logic         grant_ready,
    output logic [W-1:0] code,
    output logic [N-1:0] onehot,
    output logic         multi,
    output logic         zero
);

    logic         grant_valid_q, grant_valid_d;
    logic [W-1:0] code_q, code_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic         multi_q, multi_d;
    logic         zero_q, zero_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         accept;
    logic [W-1:0] sel_code;
    logic         sel_zero;
    logic         sel_multi;
    logic         found;
    int unsigned  idx;

    assign req_ready = !grant_valid_q || grant_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        sel_code  = '0;
        found     = 1'b0;
        idx       = 0;
        sel_zero  = (req == '0);
        sel_multi = ($countones(req) > 1);
        if (MODE == 2) begin
            // Search ptr, ptr+1, ..., wrapping at N rather than 2^W.
            for (int unsigned k = 0; k < N; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && req[idx[W-1:0]]) begin
                    sel_code = idx[W-1:0];
                    found    = 1'b1;
                end
            end
        end else if (MODE == 1) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (req[i]) begin
                    sel_code = W'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req[i]) begin
                    sel_code = W'(i);
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_valid_d = grant_valid_q;
        code_d        = code_q;
        onehot_d      = onehot_q;
        multi_d       = multi_q;
        zero_d        = zero_q;
        ptr_d         = ptr_q;
        if (accept) begin
            grant_valid_d = 1'b1;
            code_d        = sel_code;
            onehot_d      = '0;
            if (!sel_zero) begin
                onehot_d[sel_code] = 1'b1;
            end
            multi_d = sel_multi;
            zero_d  = sel_zero;
            if (MODE == 2 && !sel_zero) begin
                ptr_d = (sel_code == W'(N - 1)) ? '0 : sel_code + 1'b1;
            end
        end else if (grant_ready) begin
            grant_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            grant_valid_q <= 1'b0;
            code_q        <= '0;
            onehot_q      <= '0;
            multi_q       <= 1'b0;
            zero_q        <= 1'b0;
            ptr_q         <= '0;
        end else begin
            grant_valid_q <= grant_valid_d;
            code_q        <= code_d;
            onehot_q      <= onehot_d;
            multi_q       <= multi_d;
            zero_q        <= zero_d;
            ptr_q         <= ptr_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign code        = code_q;
    assign onehot      = onehot_q;
    assign multi       = multi_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_prio_encoder_rr_pipe.sv
// Bench for prio_encoder_rr_pipe: one instance per MODE sharing stimulus, compared against a
// behavioural model of winner selection, rotating pointer and handshake.
module tb_prio_encoder_rr_pipe;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req = '0;
    logic       grant_ready = 1'b0;

    logic       rdy_a   [3];
    logic       gv_a    [3];
    logic [2:0] code_a  [3];
    logic [7:0] oh_a    [3];
    logic       multi_a [3];
    logic       zero_a  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        prio_encoder_rr_pipe #(.N(8), .W(3), .MODE(g)) u_dut (
            .clk         (clk),
            .reset_p     (reset_p),
            .req_valid   (req_valid),
            .req_ready   (rdy_a[g]),
            .req         (req),
            .grant_valid (gv_a[g]),
            .grant_ready (grant_ready),
            .code        (code_a[g]),
            .onehot      (oh_a[g]),
            .multi       (multi_a[g]),
            .zero        (zero_a[g])
        );
    end

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic       exp_gv;
    int         exp_code  [3];
    logic [7:0] exp_oh    [3];
    logic       exp_multi [3];
    logic       exp_zero  [3];
    int         exp_ptr;

    function automatic int winner(int mode, logic [7:0] r, int p);
        if (mode == 0) begin
            for (int i = 0; i < 8; i++) if (r[i]) return i;
        end else if (mode == 1) begin
            for (int i = 7; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int j = 0; j < 8; j++) if (r[(p + j) % 8]) return (p + j) % 8;
        end
        return 0;
    endfunction

    function automatic int popcount(logic [7:0] r);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(r[i]);
        return c;
    endfunction

    task automatic model_clear();
        exp_gv  = 1'b0;
        exp_ptr = 0;
        for (int m = 0; m < 3; m++) begin
            exp_code[m] = 0; exp_oh[m] = '0; exp_multi[m] = 1'b0; exp_zero[m] = 1'b0;
        end
    endtask

    task automatic drive(logic v, logic [7:0] r, logic gr);
        req_valid = v; req = r; grant_ready = gr;
    endtask

    // Advance one clock edge and update the model with the inputs currently driven.
    task automatic tick();
        logic acc;
        acc = req_valid && (!exp_gv || grant_ready);
        @(posedge clk);
        if (acc) begin
            for (int m = 0; m < 3; m++) begin
                exp_code[m]  = winner(m, req, exp_ptr);
                exp_zero[m]  = (req == 8'h00);
                exp_multi[m] = popcount(req) > 1;
                exp_oh[m]    = exp_zero[m] ? 8'h00 : 8'(1 << exp_code[m]);
            end
            if (req != 8'h00) exp_ptr = (exp_code[2] + 1) % 8;
            exp_gv = 1'b1;
        end else if (grant_ready) begin
            exp_gv = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset_p = 1'b1;
        #3;
        reset_p = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h00, 1'b0);
        model_clear();
        #2;
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if ({gv_a[m], code_a[m], oh_a[m], multi_a[m], zero_a[m]} !== 14'd0) begin
                n_fail++;
                $display("FAIL reset m%0d: gv=%b code=%0d oh=%h multi=%b zero=%b, want all 0",
                         m, gv_a[m], code_a[m], oh_a[m], multi_a[m], zero_a[m]);
            end
            n_checks++;
            if (rdy_a[m] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready m%0d: got %b want 1", m, rdy_a[m]);
            end
        end
        reset_p = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed();
        drive(1'b1, 8'hA4, 1'b1);
        tick();
        n_checks++;
        if ({gv_a[0], code_a[0], oh_a[0], multi_a[0], zero_a[0]} !== {1'b1, 3'd2, 8'h04, 2'b10}) begin
            n_fail++;
            $display("FAIL lsb_a4: gv=%b code=%0d oh=%h multi=%b zero=%b, want 1 2 04 1 0",
                     gv_a[0], code_a[0], oh_a[0], multi_a[0], zero_a[0]);
        end
        n_checks++;
        if ({gv_a[1], code_a[1], oh_a[1], multi_a[1], zero_a[1]} !== {1'b1, 3'd7, 8'h80, 2'b10}) begin
            n_fail++;
            $display("FAIL msb_a4: gv=%b code=%0d oh=%h multi=%b zero=%b, want 1 7 80 1 0",
                     gv_a[1], code_a[1], oh_a[1], multi_a[1], zero_a[1]);
        end
        drive(1'b1, 8'h10, 1'b1);
        tick();
        n_checks++;
        if ({code_a[1], oh_a[1], multi_a[1]} !== {3'd4, 8'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL msb_10: code=%0d oh=%h multi=%b, want 4 10 0",
                     code_a[1], oh_a[1], multi_a[1]);
        end
        drive(1'b0, 8'h00, 1'b1);
        tick();
        n_checks++;
        if (gv_a[0] !== 1'b0 || code_a[0] !== 3'd4 || oh_a[0] !== 8'h10) begin
            n_fail++;
            $display("FAIL consume_hold: gv=%b code=%0d oh=%h, want 0 4 10",
                     gv_a[0], code_a[0], oh_a[0]);
        end
    endtask

    task automatic test_rr_wrap();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 8'hFF, 1'b1);
            tick();
            n_checks++;
            if (gv_a[2] !== 1'b1 || code_a[2] !== 3'(i % 8)) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: gv=%b code=%0d, want 1 %0d", i, gv_a[2], code_a[2], i % 8);
            end
        end
        drive(1'b1, 8'h81, 1'b1);
        tick();
        n_checks++;
        if (code_a[2] !== 3'd7 || oh_a[2] !== 8'h80) begin
            n_fail++;
            $display("FAIL rr_81: code=%0d oh=%h, want 7 80", code_a[2], oh_a[2]);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive(1'b1, 8'hA4, 1'b0);
        tick();
        drive(1'b1, 8'h18, 1'b0);
        #1;
        n_checks++;
        if (rdy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready: got %b want 0", rdy_a[0]);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (gv_a[0] !== 1'b1 || code_a[0] !== 3'd2 || oh_a[0] !== 8'h04 || code_a[1] !== 3'd7) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: gv=%b code0=%0d oh0=%h code1=%0d, want 1 2 04 7",
                         c, gv_a[0], code_a[0], oh_a[0], code_a[1]);
            end
        end
        drive(1'b1, 8'h18, 1'b1);
        #1;
        n_checks++;
        if (rdy_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", rdy_a[0]);
        end
        tick();
        n_checks++;
        if (gv_a[0] !== 1'b1 || code_a[0] !== 3'd3 || code_a[1] !== 3'd4 || multi_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_reload: gv=%b code0=%0d code1=%0d multi=%b, want 1 3 4 1",
                     gv_a[0], code_a[0], code_a[1], multi_a[0]);
        end
    endtask

    task automatic test_zero();
        apply_reset();
        drive(1'b1, 8'hFF, 1'b1);
        tick();
        drive(1'b1, 8'h00, 1'b1);
        tick();
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if ({gv_a[m], code_a[m], oh_a[m], multi_a[m], zero_a[m]} !== {1'b1, 3'd0, 8'h00, 2'b01}) begin
                n_fail++;
                $display("FAIL zero m%0d: gv=%b code=%0d oh=%h multi=%b zero=%b, want 1 0 00 0 1",
                         m, gv_a[m], code_a[m], oh_a[m], multi_a[m], zero_a[m]);
            end
        end
        drive(1'b1, 8'hFF, 1'b1);
        tick();
        n_checks++;
        if (code_a[2] !== 3'd1 || zero_a[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_keeps_ptr: code=%0d zero=%b, want 1 0", code_a[2], zero_a[2]);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'hFF, 1'b0);
        tick();
        #2;
        reset_p = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if ({gv_a[m], code_a[m], oh_a[m], multi_a[m], zero_a[m]} !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_mid m%0d: gv=%b code=%0d oh=%h multi=%b zero=%b, want all 0",
                         m, gv_a[m], code_a[m], oh_a[m], multi_a[m], zero_a[m]);
            end
        end
        reset_p = 1'b0;
        model_clear();
        drive(1'b1, 8'hFF, 1'b1);
        tick();
        n_checks++;
        if (gv_a[2] !== 1'b1 || code_a[2] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_ptr: gv=%b code=%0d, want 1 0", gv_a[2], code_a[2]);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        for (int c = 0; c < 300; c++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 5) == 0) r = 8'h00;
            drive(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0));
            #1;
            n_checks++;
            if (rdy_a[2] !== (!exp_gv || grant_ready)) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, rdy_a[2], !exp_gv || grant_ready);
            end
            tick();
            for (int m = 0; m < 3; m++) begin
                n_checks++;
                if (gv_a[m] !== exp_gv || code_a[m] !== 3'(exp_code[m]) || oh_a[m] !== exp_oh[m] ||
                    multi_a[m] !== exp_multi[m] || zero_a[m] !== exp_zero[m]) begin
                    n_fail++;
                    $display("FAIL rand[%0d] m%0d: gv=%b code=%0d oh=%h multi=%b zero=%b, want %b %0d %h %b %b",
                             c, m, gv_a[m], code_a[m], oh_a[m], multi_a[m], zero_a[m],
                             exp_gv, exp_code[m], exp_oh[m], exp_multi[m], exp_zero[m]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_wrap();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
